alu_instr_sequencer: RTL and testbench
======================================

Name: alu_instr_sequencer

Overview:
- Parametrised control-unit sequencer for the datapath's three-operand register ALU instructions.
- Replaces hard-wired per-instruction T-state sequences with one FSM:
  - fetch (T0–T2), then execute (T3–T5/T6);
  - register strobes are decoded from the latched IR fields, so any opcode and register triple is handled.
- Adds a start/done handshake, a memory-ready wait state, HI/LO writeback for MUL/DIV, and illegal-instruction detection.
- Sits between the top-level controller/bench and the datapath control inputs.

Parameters:
- NUM_REGS, 16, number of general registers; width of Rin/Rout vectors.
- DATA_W, 32, IR width.
- OPC_W, 5, opcode field width (IR[DATA_W-1 -: OPC_W]).
- RF_W, 4, register field width; fields are Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15] (for defaults).

Ports:
- Clock, in, 1: system clock; all state changes on the rising edge.
- Clear, in, 1: asynchronous, active-low reset.
- start, in, 1: begin an instruction; sampled in IDLE only.
- mem_ready, in, 1: memory read data valid; sampled in T1.
- ir_in, in, DATA_W: instruction value presented by the IR/MDR for sampling at the end of T2.
- PCout, Zlowout, ZHighout, MDRout, out, 1 each: bus source selects.
- MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin, out, 1 each: register load enables.
- IncPC, Read, out, 1 each: PC increment and memory read.
- alu_op, out, OPC_W: ALU operation; 0 when no ALU op is active.
- Rin, out, NUM_REGS: one-hot register load enable.
- Rout, out, NUM_REGS: one-hot register bus drive.
- busy, out, 1: high from T0 through the last T-state.
- done, out, 1: one-cycle pulse after the last T-state.
- illegal, out, 1: sticky illegal-instruction flag; cleared only by reset or by the next start.

Behaviour:
- Reset (Clear=0, asynchronous):
  - state goes to IDLE, the IR latch clears to 0, every output is 0.
  - Reset applied mid-instruction aborts it immediately; no done pulse is produced.
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, FIN.
- Outputs are Moore-decoded from the state and the IR latch. No input reaches an output combinationally.
- IDLE:
  - start=1 → T0.
  - start is ignored in every other state.
- T0: PCout, MARin, IncPC, Zin.
- T1: Zlowout, PCin, Read, MDRin.
  - Stays in T1 while mem_ready=0; re-asserting PCin is harmless because Z is unchanged.
  - mem_ready=1 → T2.
- T2: MDRout, IRin.
  - ir_in is latched into the IR latch at the end of T2.
  - Opcode or any used register field outside the legal set → set illegal, go to FIN, assert no register strobes.
- T3: Rout[Rb], Yin.
- T4: Rout[Rc], alu_op=opcode, Zin.
  - Unary ops (NEG, NOT) drive Rout[Rb] instead of Rout[Rc].
- T5:
  - Normal ops: Zlowout, Rin[Ra] → FIN.
  - MUL/DIV: Zlowout, LOin → T6.
- T6 (MUL/DIV only): ZHighout, HIin → FIN.
- FIN: done=1 for one cycle.
  - start=1 → T0 (back-to-back, no IDLE cycle).
  - Otherwise → IDLE.
- Rin/Rout are exactly one-hot when active and all-zero otherwise. A field value ≥ NUM_REGS is illegal.
- Latency from start to done (mem_ready tied high):
  - 7 cycles for normal ops;
  - 8 cycles for MUL/DIV;
  - plus one cycle per T1 wait cycle.

Optional Feature:
- SEQ_SINGLE_STEP_EN, defined:
  - adds input step (1 bit);
  - every transition except IDLE→T0 and T1 waits also requires step=1 in that cycle;
  - outputs are held while stalled.
- Undefined: no step port; free-running as specified above.

Decomposition:
- Package alu_seq_pkg holds:
  - the state enum;
  - opcode constants (ADD 00011, SUB 00100, SHR 00101, SHL 00110, ROR 00111, ROL 01000, AND 01001, OR 01010, MUL 01111, DIV 10000, NEG 10001, NOT 10010);
  - the functions is_legal_op and is_unary, is_hilo.
- One sub-module, reg_onehot_dec (RF_W in → NUM_REGS one-hot out, with enable), instantiated twice for Rin and Rout.

Test Plan:
- AND: IR=32'h4A920000, mem_ready=1, pulse start.
  - T3: Rout=16'h0004, Yin=1.
  - T4: Rout=16'h0010, alu_op=01001, Zin=1.
  - T5: Rin=16'h0020, Zlowout=1.
  - done arrives 7 cycles after start.
- MUL: IR=32'h7A920000 (opcode 01111).
  - T5: LOin=1, Zlowout=1.
  - T6: HIin=1, ZHighout=1.
  - No Rin asserted; done after 8 cycles.
- Memory wait: hold mem_ready=0 for 3 cycles in T1.
  - Read and MDRin stay high for 4 cycles.
  - IRin is asserted only after mem_ready=1.
  - done after 10 cycles.
- Illegal: opcode 11111.
  - illegal=1 after T2, then FIN.
  - Rin, Rout, Zin are never asserted after T2.
  - The next start clears illegal.
- Reset mid-T4 (Clear low for 1 ns):
  - all outputs 0 immediately, state IDLE, no done pulse.
  - The next start runs a clean T0.
- Back-to-back: start held high through FIN.
  - T0 follows FIN directly; done pulses once per instruction; busy stays low for the FIN cycle only.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: state encoding, opcode constants and opcode classification
// helpers shared by the ALU instruction sequencer.
`default_nettype none

package alu_seq_pkg;

   typedef enum logic [3:0] {
      S_IDLE = 4'd0,
      S_T0   = 4'd1,
      S_T1   = 4'd2,
      S_T2   = 4'd3,
      S_T3   = 4'd4,
      S_T4   = 4'd5,
      S_T5   = 4'd6,
      S_T6   = 4'd7,
      S_FIN  = 4'd8
   } seq_state_t;

   localparam logic [4:0] OP_ADD = 5'b00011;
   localparam logic [4:0] OP_SUB = 5'b00100;
   localparam logic [4:0] OP_SHR = 5'b00101;
   localparam logic [4:0] OP_SHL = 5'b00110;
   localparam logic [4:0] OP_ROR = 5'b00111;
   localparam logic [4:0] OP_ROL = 5'b01000;
   localparam logic [4:0] OP_AND = 5'b01001;
   localparam logic [4:0] OP_OR  = 5'b01010;
   localparam logic [4:0] OP_MUL = 5'b01111;
   localparam logic [4:0] OP_DIV = 5'b10000;
   localparam logic [4:0] OP_NEG = 5'b10001;
   localparam logic [4:0] OP_NOT = 5'b10010;

   // Opcodes are passed zero-extended to 32 bits so any OPC_W can use these.
   function automatic logic is_legal_op(input logic [31:0] op);
      case (op)
         32'(OP_ADD), 32'(OP_SUB), 32'(OP_SHR), 32'(OP_SHL),
         32'(OP_ROR), 32'(OP_ROL), 32'(OP_AND), 32'(OP_OR),
         32'(OP_MUL), 32'(OP_DIV), 32'(OP_NEG), 32'(OP_NOT): return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic is_unary(input logic [31:0] op);
      return (op == 32'(OP_NEG)) || (op == 32'(OP_NOT));
   endfunction

   function automatic logic is_hilo(input logic [31:0] op);
      return (op == 32'(OP_MUL)) || (op == 32'(OP_DIV));
   endfunction

endpackage

`default_nettype wire

// File: rtl/reg_onehot_dec.sv
// reg_onehot_dec: register-field to one-hot strobe decoder with enable;
// field values beyond NUM_REGS decode to all-zero.
`default_nettype none

module reg_onehot_dec #(
   parameter int RF_W     = 4,
   parameter int NUM_REGS = 16
) (
   input  logic                en,
   input  logic [RF_W-1:0]     sel,
   output logic [NUM_REGS-1:0] onehot
);

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_bit
      assign onehot[i] = en && (32'(sel) == i);
   end

endmodule

`default_nettype wire

// File: rtl/alu_instr_sequencer.sv
// alu_instr_sequencer: fetch/execute FSM producing datapath control strobes
// for three-operand ALU instructions. Optional macro SEQ_SINGLE_STEP_EN adds a step gate.
`default_nettype none

module alu_instr_sequencer
   import alu_seq_pkg::*;
#(
   parameter int NUM_REGS = 16,
   parameter int DATA_W   = 32,
   parameter int OPC_W    = 5,
   parameter int RF_W     = 4
) (
   input  logic                Clock,
   input  logic                Clear,
`ifdef SEQ_SINGLE_STEP_EN
   input  logic                step,
`endif
   input  logic                start,
   input  logic                mem_ready,
   input  logic [DATA_W-1:0]   ir_in,
   output logic                PCout,
   output logic                Zlowout,
   output logic                ZHighout,
   output logic                MDRout,
   output logic                MARin,
   output logic                PCin,
   output logic                MDRin,
   output logic                IRin,
   output logic                Yin,
   output logic                Zin,
   output logic                HIin,
   output logic                LOin,
   output logic                IncPC,
   output logic                Read,
   output logic [OPC_W-1:0]    alu_op,
   output logic [NUM_REGS-1:0] Rin,
   output logic [NUM_REGS-1:0] Rout,
   output logic                busy,
   output logic                done,
   output logic                illegal
);

   localparam int OPC_LSB = DATA_W - OPC_W;
   localparam int RA_LSB  = OPC_LSB - RF_W;
   localparam int RB_LSB  = RA_LSB - RF_W;
   localparam int RC_LSB  = RB_LSB - RF_W;

   seq_state_t        state;
   seq_state_t        state_nx;
   logic [DATA_W-1:0] ir_lat;
   logic              adv;
   logic              accept_start;

   logic [OPC_W-1:0] in_op, op;
   logic [RF_W-1:0]  in_ra, in_rb, in_rc, ra, rb, rc;
   logic             in_legal;
   logic             op_unary, op_hilo;

   logic             rin_en, rout_en;
   logic [RF_W-1:0]  rin_sel, rout_sel;
   logic             unused_ir_bits;

`ifdef SEQ_SINGLE_STEP_EN
   assign adv = step;
`else
   assign adv = 1'b1;
`endif

   assign in_op = ir_in[DATA_W-1 -: OPC_W];
   assign in_ra = ir_in[RA_LSB +: RF_W];
   assign in_rb = ir_in[RB_LSB +: RF_W];
   assign in_rc = ir_in[RC_LSB +: RF_W];

   assign op = ir_lat[DATA_W-1 -: OPC_W];
   assign ra = ir_lat[RA_LSB +: RF_W];
   assign rb = ir_lat[RB_LSB +: RF_W];
   assign rc = ir_lat[RC_LSB +: RF_W];

   assign op_unary = is_unary(32'(op));
   assign op_hilo  = is_hilo(32'(op));

   assign unused_ir_bits = ^ir_lat[RC_LSB-1:0];

   // Only fields the opcode actually uses are range-checked: unary ops have no
   // Rc operand and MUL/DIV write HI/LO instead of Ra.
   assign in_legal = is_legal_op(32'(in_op))
                  && (32'(in_rb) < NUM_REGS)
                  && (is_unary(32'(in_op)) || (32'(in_rc) < NUM_REGS))
                  && (is_hilo(32'(in_op))  || (32'(in_ra) < NUM_REGS));

   assign accept_start = start && ((state == S_IDLE) || ((state == S_FIN) && adv));

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: if (start) state_nx = S_T0;
         S_T0:   if (adv) state_nx = S_T1;
         S_T1:   if (mem_ready && adv) state_nx = S_T2;
         S_T2:   if (adv) state_nx = in_legal ? S_T3 : S_FIN;
         S_T3:   if (adv) state_nx = S_T4;
         S_T4:   if (adv) state_nx = S_T5;
         S_T5:   if (adv) state_nx = op_hilo ? S_T6 : S_FIN;
         S_T6:   if (adv) state_nx = S_FIN;
         S_FIN:  if (adv) state_nx = start ? S_T0 : S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge Clock or negedge Clear) begin
      if (!Clear) begin
         state   <= S_IDLE;
         ir_lat  <= '0;
         illegal <= 1'b0;
      end else begin
         state <= state_nx;
         if ((state == S_T2) && adv) ir_lat <= ir_in;
         if (accept_start)
            illegal <= 1'b0;
         else if ((state == S_T2) && adv && !in_legal)
            illegal <= 1'b1;
      end
   end

   always_comb begin
      PCout    = 1'b0;
      Zlowout  = 1'b0;
      ZHighout = 1'b0;
      MDRout   = 1'b0;
      MARin    = 1'b0;
      PCin     = 1'b0;
      MDRin    = 1'b0;
      IRin     = 1'b0;
      Yin      = 1'b0;
      Zin      = 1'b0;
      HIin     = 1'b0;
      LOin     = 1'b0;
      IncPC    = 1'b0;
      Read     = 1'b0;
      alu_op   = '0;
      rin_en   = 1'b0;
      rin_sel  = ra;
      rout_en  = 1'b0;
      rout_sel = rb;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         S_T0: begin
            PCout = 1'b1;
            MARin = 1'b1;
            IncPC = 1'b1;
            Zin   = 1'b1;
            busy  = 1'b1;
         end
         S_T1: begin
            Zlowout = 1'b1;
            PCin    = 1'b1;
            Read    = 1'b1;
            MDRin   = 1'b1;
            busy    = 1'b1;
         end
         S_T2: begin
            MDRout = 1'b1;
            IRin   = 1'b1;
            busy   = 1'b1;
         end
         S_T3: begin
            rout_en = 1'b1;
            Yin     = 1'b1;
            busy    = 1'b1;
         end
         S_T4: begin
            rout_en  = 1'b1;
            rout_sel = op_unary ? rb : rc;
            alu_op   = op;
            Zin      = 1'b1;
            busy     = 1'b1;
         end
         S_T5: begin
            Zlowout = 1'b1;
            LOin    = op_hilo;
            rin_en  = !op_hilo;
            busy    = 1'b1;
         end
         S_T6: begin
            ZHighout = 1'b1;
            HIin     = 1'b1;
            busy     = 1'b1;
         end
         S_FIN: done = 1'b1;
         default: ;
      endcase
   end

   reg_onehot_dec #(.RF_W(RF_W), .NUM_REGS(NUM_REGS)) u_rin_dec (
      .en     (rin_en),
      .sel    (rin_sel),
      .onehot (Rin)
   );

   reg_onehot_dec #(.RF_W(RF_W), .NUM_REGS(NUM_REGS)) u_rout_dec (
      .en     (rout_en),
      .sel    (rout_sel),
      .onehot (Rout)
   );

endmodule

`default_nettype wire

// File: tb/tb_alu_instr_sequencer.sv
// tb_alu_instr_sequencer: builds a per-cycle expected-output schedule from the
// instruction-level rules, drives it, and compares the DUT every cycle.
`default_nettype none

module tb_alu_instr_sequencer;

   localparam int P_IDLE = 0, P_T0 = 1, P_T1 = 2, P_T2 = 3, P_T3 = 4,
                  P_T4 = 5, P_T5 = 6, P_T6 = 7, P_FIN = 8;

   typedef struct packed {
      logic pcout, zlowout, zhighout, mdrout, marin, pcin, mdrin, irin;
      logic yin, zin, hiin, loin, incpc, read;
      logic [4:0]  alu_op;
      logic [15:0] rin, rout;
      logic busy, done, illegal;
   } outs_t;

   typedef struct {
      logic        start;
      logic        mem_ready;
      logic [31:0] ir;
      logic        abort;
      int          lat;
      outs_t       exp;
   } rec_t;

   logic        Clock = 1'b0;
   logic        Clear = 1'b1;
   logic        start = 1'b0;
   logic        mem_ready = 1'b0;
   logic [31:0] ir_in = '0;
   logic        PCout, Zlowout, ZHighout, MDRout, MARin, PCin, MDRin, IRin;
   logic        Yin, Zin, HIin, LOin, IncPC, Read, busy, done, illegal;
   logic [4:0]  alu_op;
   logic [15:0] Rin, Rout;

   int    checks = 0;
   int    failures = 0;
   rec_t  q[$];
   rec_t  cur;
   logic  valid = 1'b0;
   int    cyc = 0;
   logic  ill_m = 1'b0;
   logic  last_fin = 1'b0;
   logic  pend = 1'b0;
   int    s_cyc = 0;
   int    lat_exp = 0;

   logic [4:0] legal_ops [12] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110,
                                  5'b00111, 5'b01000, 5'b01001, 5'b01010,
                                  5'b01111, 5'b10000, 5'b10001, 5'b10010};

   alu_instr_sequencer dut (
      .Clock(Clock), .Clear(Clear), .start(start), .mem_ready(mem_ready),
      .ir_in(ir_in), .PCout(PCout), .Zlowout(Zlowout), .ZHighout(ZHighout),
      .MDRout(MDRout), .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
      .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin), .IncPC(IncPC),
      .Read(Read), .alu_op(alu_op), .Rin(Rin), .Rout(Rout), .busy(busy),
      .done(done), .illegal(illegal)
   );

   always #5 Clock = ~Clock;

   function automatic logic op_legal(input logic [31:0] ins);
      foreach (legal_ops[i]) if (ins[31:27] == legal_ops[i]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic op_hilo(input logic [31:0] ins);
      return ins[31:27] == 5'b01111 || ins[31:27] == 5'b10000;
   endfunction

   function automatic logic op_unary(input logic [31:0] ins);
      return ins[31:27] == 5'b10001 || ins[31:27] == 5'b10010;
   endfunction

   // Control strobes each T-state must show for a given instruction.
   function automatic outs_t model_out(input int ph, input logic [31:0] ins, input logic ill);
      outs_t o;
      o = '0;
      o.illegal = ill;
      case (ph)
         P_T0: begin o.pcout = 1; o.marin = 1; o.incpc = 1; o.zin = 1; o.busy = 1; end
         P_T1: begin o.zlowout = 1; o.pcin = 1; o.read = 1; o.mdrin = 1; o.busy = 1; end
         P_T2: begin o.mdrout = 1; o.irin = 1; o.busy = 1; end
         P_T3: begin o.rout = 16'd1 << ins[22:19]; o.yin = 1; o.busy = 1; end
         P_T4: begin
            o.rout   = 16'd1 << (op_unary(ins) ? ins[22:19] : ins[18:15]);
            o.alu_op = ins[31:27];
            o.zin    = 1;
            o.busy   = 1;
         end
         P_T5: begin
            o.zlowout = 1;
            o.busy    = 1;
            if (op_hilo(ins)) o.loin = 1;
            else o.rin = 16'd1 << ins[26:23];
         end
         P_T6: begin o.zhighout = 1; o.hiin = 1; o.busy = 1; end
         P_FIN: o.done = 1;
         default: ;
      endcase
      return o;
   endfunction

   function automatic outs_t actual();
      outs_t a;
      a = {PCout, Zlowout, ZHighout, MDRout, MARin, PCin, MDRin, IRin,
           Yin, Zin, HIin, LOin, IncPC, Read, alu_op, Rin, Rout, busy, done, illegal};
      return a;
   endfunction

   task automatic check_out(input string nm, input outs_t act, input outs_t exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", nm, act, exp);
      end
   endtask

   task automatic check_int(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
      end
   endtask

   task automatic push(input int ph, input logic [31:0] ins, input logic st,
                       input logic mr, input logic [31:0] drv);
      rec_t r;
      r.start = st; r.mem_ready = mr; r.ir = drv; r.abort = 1'b0; r.lat = 0;
      r.exp = model_out(ph, ins, ill_m);
      q.push_back(r);
   endtask

   task automatic push_idle(input int n);
      for (int i = 0; i < n; i++) push(P_IDLE, '0, 1'b0, 1'(($urandom_range(0, 1))), $urandom());
      last_fin = 1'b0;
   endtask

   task automatic add_instr(input logic [31:0] ins, input int waits, input logic b2b,
                            input logic abort_t4);
      int lat;
      lat = op_legal(ins) ? ((op_hilo(ins) ? 8 : 7) + waits) : 4 + waits;
      if (abort_t4) lat = 0;
      if (b2b && last_fin) q[q.size()-1].start = 1'b1;
      else push(P_IDLE, '0, 1'b1, 1'(($urandom_range(0, 1))), $urandom());
      q[q.size()-1].lat = lat;
      ill_m = 1'b0;
      push(P_T0, ins, 1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))), $urandom());
      for (int w = 0; w < waits; w++) push(P_T1, ins, 1'(($urandom_range(0, 1))), 1'b0, $urandom());
      push(P_T1, ins, 1'(($urandom_range(0, 1))), 1'b1, $urandom());
      push(P_T2, ins, 1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))), ins);
      if (!op_legal(ins)) begin
         ill_m = 1'b1;
      end else begin
         push(P_T3, ins, 1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))), $urandom());
         if (abort_t4) begin
            push(P_IDLE, '0, 1'b0, 1'(($urandom_range(0, 1))), $urandom());
            q[q.size()-1].abort = 1'b1;
            last_fin = 1'b0;
            return;
         end
         push(P_T4, ins, 1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))), $urandom());
         push(P_T5, ins, 1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))), $urandom());
         if (op_hilo(ins))
            push(P_T6, ins, 1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))), $urandom());
      end
      push(P_FIN, ins, 1'b0, 1'(($urandom_range(0, 1))), $urandom());
      last_fin = 1'b1;
   endtask

   // Compare process: every scheduled cycle, plus start-to-done latency.
   always @(negedge Clock) begin
      if (valid) begin
         check_out($sformatf("cyc%0d", cyc), actual(), cur.exp);
         if (pend && done && cyc > s_cyc) begin
            check_int($sformatf("latency_from_cyc%0d", s_cyc), cyc - s_cyc, lat_exp);
            pend = 1'b0;
         end else if (pend && (cyc - s_cyc) > lat_exp + 2) begin
            check_int($sformatf("done_timeout_from_cyc%0d", s_cyc), cyc - s_cyc, lat_exp);
            pend = 1'b0;
         end
         if (cur.start && cur.lat != 0) begin
            pend    = 1'b1;
            s_cyc   = cyc;
            lat_exp = cur.lat;
         end
      end
   end

   initial begin
      logic [31:0] ins;
      int          waits;
      logic        b2b;

      add_instr(32'h4A920000, 0, 1'b0, 1'b0);
      add_instr(32'h7A920000, 0, 1'b1, 1'b0);
      push_idle(2);
      add_instr(32'h4A920000, 3, 1'b0, 1'b0);
      add_instr(32'hFA920000, 0, 1'b0, 1'b0);
      add_instr(32'h4A920000, 0, 1'b1, 1'b0);
      push_idle(1);
      add_instr(32'h1A920000, 0, 1'b0, 1'b1);
      push_idle(1);
      add_instr(32'h8A920000, 1, 1'b0, 1'b0);
      for (int k = 0; k < 40; k++) begin
         ins = $urandom();
         if ($urandom_range(0, 9) < 8) ins[31:27] = legal_ops[$urandom_range(0, 11)];
         waits = $urandom_range(0, 3);
         b2b = last_fin && ($urandom_range(0, 2) == 0);
         if (!b2b) push_idle($urandom_range(0, 2));
         add_instr(ins, waits, b2b, 1'b0);
      end
      push_idle(3);

      check_int("and_t3_rout", int'(q[4].exp.rout), 32'h0004);
      check_int("and_t4_rout", int'(q[5].exp.rout), 32'h0010);
      check_int("and_t4_aluop", int'(q[5].exp.alu_op), 32'h09);
      check_int("and_t5_rin", int'(q[6].exp.rin), 32'h0020);
      check_int("mul_t5_loin_norin", int'({q[13].exp.loin, q[13].exp.rin}), 32'h10000);
      check_int("mul_t6_hiin", int'({q[14].exp.hiin, q[14].exp.zhighout}), 3);

      #2 Clear = 1'b0;
      #10 check_out("reset_state", actual(), '0);
      @(negedge Clock);
      Clear = 1'b1;

      for (int i = 0; i < q.size(); i++) begin
         @(posedge Clock);
         #1;
         start     = q[i].start;
         mem_ready = q[i].mem_ready;
         ir_in     = q[i].ir;
         cur       = q[i];
         cyc       = i;
         valid     = 1'b1;
         if (q[i].abort) begin
            #2 Clear = 1'b0;
            #1 check_out("abort_outputs_zero", actual(), '0);
            Clear = 1'b1;
         end
      end
      @(posedge Clock);
      #1 valid = 1'b0;
      if (pend) check_int("done_never_seen", 0, lat_exp);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
